// File: rtl/card_pkg.sv
`default_nettype none
// ============================================================================
// Module  : card_pkg
// Purpose : Shared constants, state encodings and helpers for the card dealer.
// Revision: 1.0 - initial release
// ============================================================================
package card_pkg;

  localparam int DECK_SIZE = 52;

  typedef logic [3:0] rank_t;

  localparam rank_t RANK_J = 4'd11;
  localparam rank_t RANK_Q = 4'd12;
  localparam rank_t RANK_K = 4'd13;

  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  localparam logic [1:0] ST_INIT    = 2'd0;
  localparam logic [1:0] ST_SH_PICK = 2'd1;
  localparam logic [1:0] ST_SH_SWAP = 2'd2;
  localparam logic [1:0] ST_READY   = 2'd3;

  // Sorted deck content: four consecutive slots per rank.
  function automatic rank_t init_rank(input logic [5:0] k);
    logic [5:0] w_r;
    w_r = (k >> 2) + 6'd1;
    return w_r[3:0];
  endfunction

  function automatic logic is_face(input rank_t r);
    return (r == RANK_J) || (r == RANK_Q) || (r == RANK_K);
  endfunction

endpackage
`default_nettype wire

// File: rtl/card_dealer_lfsr16.sv
`default_nettype none
// ============================================================================
// Module  : lfsr16
// Purpose : 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1), never all-zero.
// Revision: 1.0 - initial release
// ============================================================================
module lfsr16
  import card_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] w_seed;
  logic        w_fb;
  logic [15:0] r_q;

  assign w_seed = (seed == 16'h0000) ? LFSR_DEFAULT_SEED : seed;
  // Right-shift form of the tap set 16,14,13,11.
  assign w_fb   = r_q[0] ^ r_q[2] ^ r_q[3] ^ r_q[5];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= w_seed;
    end else if (en) begin
      r_q <= {w_fb, r_q[15:1]};
    end
  end

  assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/card_dealer.sv
`default_nettype none
// ============================================================================
// Module  : card_dealer
// Purpose : Shuffled 52-card deck dealer (Fisher-Yates shuffle, LFSR driven).
// Revision: 1.0 - initial release
// ============================================================================
module card_dealer
  import card_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          DECK_SIZE = card_pkg::DECK_SIZE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       draw_req,
  input  logic       reshuffle,
  output logic [3:0] number,
  output logic       number_valid,
  output logic       busy,
  output logic       deck_empty,
  output logic       empty_err,
  output logic [5:0] cards_left
);

  localparam logic [5:0] c_LAST = 6'(DECK_SIZE - 1);
  localparam logic [5:0] c_FULL = 6'(DECK_SIZE);

  logic [1:0]  r_state;
  logic [5:0]  r_fill;
  logic [5:0]  r_i;
  logic [5:0]  r_j;
  rank_t       r_val_i;
  rank_t       r_val_j;
  logic        r_swap_ph;
  logic [5:0]  r_cards_left;
  rank_t       r_number;
  logic        r_nv;
  logic        r_err;
  logic        r_draw_d;
  logic        r_resh_d;
  rank_t       r_deck [0:DECK_SIZE-1];

  logic [15:0] w_lfsr;
  logic [5:0]  w_j;
  logic        w_unused_lfsr;
  logic        w_draw_edge;
  logic        w_resh_edge;
  logic [5:0]  w_deal_idx;

  lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (r_state == ST_SH_PICK),
    .seed  (LFSR_SEED),
    .q     (w_lfsr)
  );

  assign w_j           = w_lfsr[5:0];
  assign w_unused_lfsr = ^w_lfsr[15:6];
  assign w_draw_edge   = draw_req & ~r_draw_d;
  assign w_resh_edge   = reshuffle & ~r_resh_d;
  assign w_deal_idx    = c_FULL - r_cards_left;

  // Deck storage: sequential fill in INIT, swap write-back in the second SWAP cycle.
  always_ff @(posedge clk) begin
    if (r_state == ST_INIT) begin
      r_deck[r_fill] <= init_rank(r_fill);
    end else if ((r_state == ST_SH_SWAP) && r_swap_ph) begin
      r_deck[r_i] <= r_val_j;
      r_deck[r_j] <= r_val_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_INIT;
      r_fill       <= 6'd0;
      r_i          <= 6'd0;
      r_j          <= 6'd0;
      r_val_i      <= 4'd0;
      r_val_j      <= 4'd0;
      r_swap_ph    <= 1'b0;
      r_cards_left <= 6'd0;
      r_number     <= 4'd0;
      r_nv         <= 1'b0;
      r_err        <= 1'b0;
      r_draw_d     <= 1'b0;
      r_resh_d     <= 1'b0;
    end else begin
      r_draw_d <= draw_req;
      r_resh_d <= reshuffle;
      r_nv     <= 1'b0;
      r_err    <= 1'b0;
      case (r_state)
        ST_INIT: begin
          if (r_fill == c_LAST) begin
            r_fill  <= 6'd0;
            r_i     <= c_LAST;
            r_state <= ST_SH_PICK;
          end else begin
            r_fill <= r_fill + 6'd1;
          end
        end
        ST_SH_PICK: begin
          // Rejection sampling keeps j uniform over 0..i without a modulo.
          if (w_j <= r_i) begin
            r_j       <= w_j;
            r_swap_ph <= 1'b0;
            r_state   <= ST_SH_SWAP;
          end
        end
        ST_SH_SWAP: begin
          if (!r_swap_ph) begin
            r_val_i   <= r_deck[r_i];
            r_val_j   <= r_deck[r_j];
            r_swap_ph <= 1'b1;
          end else begin
            r_swap_ph <= 1'b0;
            r_i       <= r_i - 6'd1;
            if (r_i == 6'd1) begin
              r_cards_left <= c_FULL;
              r_state      <= ST_READY;
            end else begin
              r_state <= ST_SH_PICK;
            end
          end
        end
        ST_READY: begin
          if (w_resh_edge) begin
            r_cards_left <= 6'd0;
            r_fill       <= 6'd0;
            r_state      <= ST_INIT;
          end else if (w_draw_edge) begin
            if (r_cards_left != 6'd0) begin
              r_number     <= r_deck[w_deal_idx];
              r_nv         <= 1'b1;
              r_cards_left <= r_cards_left - 6'd1;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

  assign number       = r_number;
  assign number_valid = r_nv;
  assign busy         = (r_state != ST_READY);
  assign deck_empty   = (r_state == ST_READY) && (r_cards_left == 6'd0);
  assign empty_err    = r_err;
  assign cards_left   = r_cards_left;

endmodule
`default_nettype wire
